// File: rtl/eye_mem_pkg.sv
// Shared types and default widths for the DRAM arbiter slice.
package eye_mem_pkg;
   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
   typedef enum logic {PORT_IF, PORT_DM} port_id_t;
endpackage

// File: rtl/dram_arbiter_if.sv
// Fetch port, data port and memory-side bus of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface dram_arbiter_if #(
   parameter int ADDR_W = eye_mem_pkg::ADDR_W_DEF,
   parameter int DATA_W = eye_mem_pkg::DATA_W_DEF
);
   logic              if_req_valid;
   logic              if_req_ready;
   logic [ADDR_W-1:0] if_addr;
   logic              if_rsp_valid;
   logic              if_rsp_ready;
   logic [DATA_W-1:0] if_rsp_data;

   logic              dm_req_valid;
   logic              dm_req_ready;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_rsp_valid;
   logic              dm_rsp_ready;
   logic [DATA_W-1:0] dm_rsp_data;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_d_in;
   logic [DATA_W-1:0] mem_d_out;

   modport slave (
      input  if_req_valid, if_addr, if_rsp_ready,
      input  dm_req_valid, dm_we, dm_addr, dm_wdata, dm_rsp_ready,
      input  mem_d_out,
      output if_req_ready, if_rsp_valid, if_rsp_data,
      output dm_req_ready, dm_rsp_valid, dm_rsp_data,
      output mem_read, mem_write, mem_addr, mem_d_in
   );

   modport master (
      output if_req_valid, if_addr, if_rsp_ready,
      output dm_req_valid, dm_we, dm_addr, dm_wdata, dm_rsp_ready,
      output mem_d_out,
      input  if_req_ready, if_rsp_valid, if_rsp_data,
      input  dm_req_ready, dm_rsp_valid, dm_rsp_data,
      input  mem_read, mem_write, mem_addr, mem_d_in
   );
endinterface

// File: rtl/rr_arb2.sv
// Two-way picker between fetch and data ports. Round-robin by default;
// with DRAM_ARB_FIXED_PRIO_EN defined the data port always wins a tie.
module rr_arb2
   import eye_mem_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     i_req_if,
   input  logic     i_req_dm,
   input  logic     i_accept,
   output logic     o_any,
   output port_id_t o_grant
);
   assign o_any = i_req_if | i_req_dm;

`ifdef DRAM_ARB_FIXED_PRIO_EN
   always_comb begin
      o_grant = i_req_dm ? PORT_DM : PORT_IF;
   end
`else
   port_id_t r_last_grant;

   // Starting from the data port means fetch wins the first tie after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= PORT_DM;
      end else if (i_accept) begin
         r_last_grant <= o_grant;
      end
   end

   always_comb begin
      if (i_req_if && i_req_dm) begin
         o_grant = (r_last_grant == PORT_IF) ? PORT_DM : PORT_IF;
      end else begin
         o_grant = i_req_dm ? PORT_DM : PORT_IF;
      end
   end
`endif
endmodule

// File: rtl/dram_arbiter.sv
// Shares one single-cycle memory between a read-only fetch port and a
// read/write data port, with one request in flight (IDLE -> ACCESS -> RESP).
module dram_arbiter
   import eye_mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic           clk,
   input  logic           rst,
   dram_arbiter_if.slave  bus,
   output logic           busy
);
   arb_state_t        r_state;
   arb_state_t        w_state_next;
   port_id_t          r_owner;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;

   logic              w_any;
   port_id_t          w_grant;
   logic              w_accept;
   logic              w_access;
   logic              w_owner_rsp_ready;

   rr_arb2 u_arb (
      .clk      (clk),
      .rst      (rst),
      .i_req_if (bus.if_req_valid),
      .i_req_dm (bus.dm_req_valid),
      .i_accept (w_accept),
      .o_any    (w_any),
      .o_grant  (w_grant)
   );

   // The picker only ever grants a valid requester, so any request in IDLE is accepted.
   assign w_accept          = (r_state == IDLE) && !rst && w_any;
   assign bus.if_req_ready  = w_accept && (w_grant == PORT_IF);
   assign bus.dm_req_ready  = w_accept && (w_grant == PORT_DM);
   assign w_owner_rsp_ready = (r_owner == PORT_IF) ? bus.if_rsp_ready : bus.dm_rsp_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_owner <= PORT_IF;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_owner <= w_grant;
            r_we    <= (w_grant == PORT_DM) ? bus.dm_we : 1'b0;
            r_addr  <= (w_grant == PORT_DM) ? bus.dm_addr : bus.if_addr;
            r_wdata <= (w_grant == PORT_DM) ? bus.dm_wdata : '0;
         end
         if (r_state == ACCESS) begin
            r_rdata <= r_we ? '0 : bus.mem_d_out;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_next = ACCESS;
         ACCESS:  w_state_next = RESP;
         RESP:    if (w_owner_rsp_ready) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Reset gates the strobes so an in-flight write never commits.
   assign w_access      = (r_state == ACCESS) && !rst;
   assign bus.mem_read  = w_access && !r_we;
   assign bus.mem_write = w_access && r_we;
   assign bus.mem_addr  = w_access ? r_addr : '0;
   assign bus.mem_d_in  = w_access ? r_wdata : '0;

   assign bus.if_rsp_valid = (r_state == RESP) && (r_owner == PORT_IF);
   assign bus.dm_rsp_valid = (r_state == RESP) && (r_owner == PORT_DM);
   assign bus.if_rsp_data  = bus.if_rsp_valid ? r_rdata : '0;
   assign bus.dm_rsp_data  = bus.dm_rsp_valid ? r_rdata : '0;

   assign busy = (r_state != IDLE);
endmodule

// File: tb/tb_dram_arbiter.sv
// Randomized plus directed bench for dram_arbiter with a transaction-level
// reference model and response scoreboard; honours DRAM_ARB_FIXED_PRIO_EN.
module tb_dram_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;

   dram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   dram_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   always #5 clk = ~clk;

   // Memory device: combinational read, write on the rising edge.
   logic [15:0] mem    [0:65535];
   logic [15:0] refmem [0:65535];
   assign bus.mem_d_out = mem[bus.mem_addr];
   always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_d_in;

   typedef struct {
      bit          dm;
      bit          we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
   } txn_t;

   txn_t sb_q[$];
   txn_t cur;
   int   ph = 0;          // 0: free, 1: memory cycle, 2: response pending
   bit   m_last_dm = 1'b1;
   bit   grant_log[$];
   bit   rand_rdy = 1'b0;
   int   vec_count = 0;
   int   err_count = 0;
   int   dm_done = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_count++;
      if (act !== exp) begin
         err_count++;
         $display("FAIL %s @%0t: got 0x%0h, required 0x%0h", name, $time, act, exp);
      end
   endtask

   // Reference model: who must be granted, what the memory sees, when responses appear.
   always @(negedge clk) begin : model
      bit any, win_dm;
      if (rst) begin
         chk("rst_if_ready", bus.if_req_ready, 0);
         chk("rst_dm_ready", bus.dm_req_ready, 0);
         chk("rst_mem_read", bus.mem_read, 0);
         chk("rst_mem_write", bus.mem_write, 0);
         ph = 0;
         sb_q.delete();
         m_last_dm = 1'b1;
      end else begin
         case (ph)
            0: begin
               any = bus.if_req_valid || bus.dm_req_valid;
`ifdef DRAM_ARB_FIXED_PRIO_EN
               win_dm = bus.dm_req_valid;
`else
               win_dm = (bus.if_req_valid && bus.dm_req_valid) ? !m_last_dm : bus.dm_req_valid;
`endif
               chk("idle_if_ready", bus.if_req_ready, any && !win_dm);
               chk("idle_dm_ready", bus.dm_req_ready, any && win_dm);
               chk("idle_busy", busy, 0);
               chk("idle_mem_rw", {bus.mem_read, bus.mem_write}, 0);
               chk("idle_mem_addr", bus.mem_addr, 0);
               chk("idle_rsp_valid", {bus.if_rsp_valid, bus.dm_rsp_valid}, 0);
               if (any) begin
                  cur.dm    = win_dm;
                  cur.we    = win_dm ? bus.dm_we : 1'b0;
                  cur.addr  = win_dm ? bus.dm_addr : bus.if_addr;
                  cur.wdata = win_dm ? bus.dm_wdata : 16'h0;
                  cur.rdata = cur.we ? 16'h0 : refmem[cur.addr];
                  sb_q.push_back(cur);
                  grant_log.push_back(bus.dm_req_ready);
                  m_last_dm = win_dm;
                  ph = 1;
               end
            end
            1: begin
               chk("acc_mem_read", bus.mem_read, !cur.we);
               chk("acc_mem_write", bus.mem_write, cur.we);
               chk("acc_mem_addr", bus.mem_addr, cur.addr);
               chk("acc_mem_d_in", bus.mem_d_in, cur.wdata);
               chk("acc_busy", busy, 1);
               chk("acc_ready", {bus.if_req_ready, bus.dm_req_ready}, 0);
               chk("acc_rsp_valid", {bus.if_rsp_valid, bus.dm_rsp_valid}, 0);
               if (cur.we) refmem[cur.addr] = cur.wdata;
               ph = 2;
            end
            default: begin
               chk("rsp_busy", busy, 1);
               chk("rsp_ready", {bus.if_req_ready, bus.dm_req_ready}, 0);
               chk("rsp_mem_rw", {bus.mem_read, bus.mem_write}, 0);
               chk("rsp_if_valid", bus.if_rsp_valid, !cur.dm);
               chk("rsp_dm_valid", bus.dm_rsp_valid, cur.dm);
               chk("rsp_if_data", bus.if_rsp_data, cur.dm ? 16'h0 : cur.rdata);
               chk("rsp_dm_data", bus.dm_rsp_data, cur.dm ? cur.rdata : 16'h0);
               if (cur.dm ? bus.dm_rsp_ready : bus.if_rsp_ready) ph = 0;
            end
         endcase
      end
   end

   // Scoreboard monitor: every delivered response must match the oldest expected one.
   always @(negedge clk) begin : monitor
      txn_t exp_t;
      if (!rst && ((bus.if_rsp_valid && bus.if_rsp_ready) || (bus.dm_rsp_valid && bus.dm_rsp_ready))) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_rsp", {bus.if_rsp_valid, bus.dm_rsp_valid}, 0);
         end else begin
            exp_t = sb_q.pop_front();
            chk("sb_port", bus.dm_rsp_valid && bus.dm_rsp_ready, exp_t.dm);
            chk("sb_data", exp_t.dm ? bus.dm_rsp_data : bus.if_rsp_data, exp_t.rdata);
         end
      end
   end

   initial begin : rsp_ready_gen
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) begin
            bus.if_rsp_ready = ($urandom_range(0, 3) != 0);
            bus.dm_rsp_ready = ($urandom_range(0, 3) != 0);
         end
      end
   end

   task automatic fetch_req(input logic [15:0] a, input int budget);
      int n = 0;
      bus.if_addr = a;
      bus.if_req_valid = 1'b1;
      do begin @(negedge clk); n++; end while (!(bus.if_req_ready && !rst) && n < budget);
      chk("if_accept", (bus.if_req_ready && !rst), 1);
      @(posedge clk);
      #1 bus.if_req_valid = 1'b0;
   endtask

   task automatic dm_req(input bit we, input logic [15:0] a, input logic [15:0] d, input int budget);
      int n = 0;
      bus.dm_we = we;
      bus.dm_addr = a;
      bus.dm_wdata = d;
      bus.dm_req_valid = 1'b1;
      do begin @(negedge clk); n++; end while (!(bus.dm_req_ready && !rst) && n < budget);
      chk("dm_accept", (bus.dm_req_ready && !rst), 1);
      @(posedge clk);
      #1 bus.dm_req_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      do begin @(negedge clk); n++; end while (!(ph == 0 && sb_q.size() == 0) && n < budget);
      chk("drain", (ph == 0 && sb_q.size() == 0), 1);
      @(posedge clk);
      #1;
   endtask

   initial begin : main
      bit exp_dm;
      for (int i = 0; i < 65536; i++) begin
         mem[i] = 16'h0;
         refmem[i] = 16'h0;
      end
      mem[16'h0010] = 16'h1234;
      refmem[16'h0010] = 16'h1234;
      bus.if_req_valid = 1'b0; bus.if_addr = '0; bus.if_rsp_ready = 1'b1;
      bus.dm_req_valid = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
      bus.dm_rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // First access after reset: fetch read of preloaded word.
      fetch_req(16'h0010, 20);
      wait_idle(20);

      // Data write followed by read-back.
      dm_req(1'b1, 16'h0020, 16'hBEEF, 20);
      dm_req(1'b0, 16'h0020, 16'h0000, 20);
      wait_idle(20);

      // Both ports requesting continuously from a fresh reset.
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      grant_log.delete();
      bus.if_addr = 16'h0010;
      bus.dm_we = 1'b0;
      bus.dm_addr = 16'h0020;
      bus.if_req_valid = 1'b1;
      bus.dm_req_valid = 1'b1;
      for (int n = 0; n < 100 && grant_log.size() < 4; n++) @(negedge clk);
      @(posedge clk);
      #1;
      bus.if_req_valid = 1'b0;
      bus.dm_req_valid = 1'b0;
      chk("tie_grant_count", grant_log.size(), 4);
      for (int i = 0; i < grant_log.size() && i < 4; i++) begin
`ifdef DRAM_ARB_FIXED_PRIO_EN
         exp_dm = 1'b1;
`else
         exp_dm = (i % 2) == 1;
`endif
         chk("tie_grant", grant_log[i], exp_dm);
      end
      wait_idle(20);

      // Fetch response back-pressured while the data port waits.
      bus.if_rsp_ready = 1'b0;
      fetch_req(16'h0010, 20);
      fork begin dm_req(1'b0, 16'h0020, 16'h0, 100); dm_done = 1; end join_none
      repeat (7) @(posedge clk);
      #1 bus.if_rsp_ready = 1'b1;
      for (int n = 0; n < 50 && dm_done == 0; n++) @(posedge clk);
      #1;
      chk("stall_dm_done", dm_done, 1);
      wait_idle(20);

      // Reset during the memory cycle of a write: nothing commits, no response.
      dm_req(1'b1, 16'h0030, 16'h5555, 20);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      dm_req(1'b0, 16'h0030, 16'h0000, 20);
      wait_idle(20);

      // Random traffic on both ports with random response back-pressure.
      rand_rdy = 1'b1;
      fork
         begin
            for (int k = 0; k < 25; k++) begin
               repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
               fetch_req(16'h0040 + 16'($urandom_range(0, 7)), 400);
            end
         end
         begin
            for (int k = 0; k < 25; k++) begin
               repeat ($urandom_range(2, 6)) begin @(posedge clk); #1; end
               dm_req(1'($urandom_range(0, 1)), 16'h0040 + 16'($urandom_range(0, 7)),
                      16'($urandom), 400);
            end
         end
      join
      rand_rdy = 1'b0;
      #1;
      bus.if_rsp_ready = 1'b1;
      bus.dm_rsp_ready = 1'b1;
      wait_idle(50);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end
endmodule
